// File: rtl/ddc_core.sv
// ddc_core: digital down-converter. Mixes real ADC samples with a runtime-tuned NCO,
// optionally integrates-and-dumps by a power-of-two factor, and emits rounded,
// saturated signed I/Q.
//
// Ports:
//   clk          rising-edge clock for all logic
//   reset        synchronous active-high reset (also reloads DEFAULT_TUNE)
//   in_data      ADC sample, IN_W bits (offset binary when IN_OFFSET_BIN = 1)
//   in_valid     sample strobe, every strobe is accepted
//   tune_data    new NCO tuning word
//   tune_valid   one-cycle load strobe for tune_data
//   phase_reset  synchronous NCO/decimator restart, flushes in-flight results
//   out_i/out_q  signed OUT_W-bit I/Q, held between strobes
//   out_valid    one-cycle strobe per output pair
module ddc_core #(
    parameter int unsigned IN_W          = 8,
    parameter bit          IN_OFFSET_BIN = 1'b1,
    parameter int unsigned OUT_W         = 8,
    parameter int unsigned PHASE_W       = 32,
    parameter int unsigned LUT_ADDR_W    = 10,
    parameter int unsigned LUT_W         = 14,
    parameter int unsigned DECIM         = 1,
    parameter logic [PHASE_W-1:0] DEFAULT_TUNE = 32'h3400_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    input  logic [PHASE_W-1:0] tune_data,
    input  logic               tune_valid,
    input  logic               phase_reset,
    output logic [OUT_W-1:0]   out_i,
    output logic [OUT_W-1:0]   out_q,
    output logic               out_valid
);

    localparam int unsigned PROD_W    = IN_W + LUT_W;
    localparam int unsigned DEC_LOG   = $clog2(DECIM);
    localparam int unsigned ACC_W     = PROD_W + DEC_LOG;
    localparam int unsigned SHIFT     = LUT_W - 1 + DEC_LOG + IN_W - OUT_W;
    // Kept integer part plus one bit of headroom for the rounding carry.
    localparam int unsigned RND_W     = ACC_W - SHIFT + 1;
    localparam int unsigned CNT_W     = (DEC_LOG > 0) ? DEC_LOG : 1;
    localparam int unsigned LUT_DEPTH = 1 << LUT_ADDR_W;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN  = ~SAT_MAX;

    localparam real TWO_PI = 6.283185307179586;
    localparam real AMP    = $itor((1 << (LUT_W - 1)) - 1);

    // Full-wave cos/sin tables, computed at elaboration.
    logic signed [LUT_W-1:0] cos_rom [LUT_DEPTH];
    logic signed [LUT_W-1:0] sin_rom [LUT_DEPTH];

    for (genvar a = 0; a < LUT_DEPTH; a++) begin : g_lut
        localparam real ANG   = TWO_PI * $itor(a) / $itor(LUT_DEPTH);
        localparam real COS_R = AMP * $cos(ANG);
        localparam real SIN_R = AMP * $sin(ANG);
        localparam int  COS_V = (COS_R >= 0.0) ? $rtoi(COS_R + 0.5) : -$rtoi(0.5 - COS_R);
        localparam int  SIN_V = (SIN_R >= 0.0) ? $rtoi(SIN_R + 0.5) : -$rtoi(0.5 - SIN_R);
        assign cos_rom[a] = LUT_W'(COS_V);
        assign sin_rom[a] = LUT_W'(SIN_V);
    end

    // Round half-to-even on the SHIFT discarded bits, then clamp to OUT_W.
    function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] v);
        logic signed [RND_W-1:0] r;
        logic                    up;
        up = v[SHIFT-1] & ((|v[SHIFT-2:0]) | v[SHIFT]);
        r  = RND_W'($signed(v[ACC_W-1:SHIFT])) + $signed(RND_W'(up));
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        return OUT_W'(r);
    endfunction

    // Pipeline registers
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [PHASE_W-1:0]       tune_q, tune_d;
    logic signed [IN_W-1:0]   x0_q, x0_d;
    logic [LUT_ADDR_W-1:0]    addr0_q, addr0_d;
    logic                     v0_q, v0_d;
    logic signed [IN_W-1:0]   x1_q, x1_d;
    logic signed [LUT_W-1:0]  cos1_q, cos1_d;
    logic signed [LUT_W-1:0]  sin1_q, sin1_d;
    logic                     v1_q, v1_d;
    logic signed [PROD_W-1:0] prod_i_q, prod_i_d;
    logic signed [PROD_W-1:0] prod_q_q, prod_q_d;
    logic                     v2_q, v2_d;
    logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  dump_i_q, dump_i_d;
    logic signed [ACC_W-1:0]  dump_q_q, dump_q_d;
    logic                     v3_q, v3_d;
    logic [OUT_W-1:0]         out_i_q, out_i_d;
    logic [OUT_W-1:0]         out_q_q, out_q_d;
    logic                     out_valid_q, out_valid_d;

    logic [PHASE_W-1:0]       phase_base_c;
    logic signed [IN_W-1:0]   x_c;
    logic signed [ACC_W-1:0]  sum_i_c, sum_q_c;

    // Next-state logic for every pipeline stage.
    always_comb begin
        // Input conversion: offset binary becomes two's complement by flipping the MSB.
        x_c = {in_data[IN_W-1] ^ IN_OFFSET_BIN, in_data[IN_W-2:0]};

        // Stage 0: phase_reset restarts the sample in this cycle at phase 0;
        // the phase advances with the word in force before any same-cycle load.
        phase_base_c = phase_reset ? '0 : phase_q;
        phase_d      = in_valid ? (phase_base_c + tune_q) : phase_base_c;
        tune_d       = tune_valid ? tune_data : tune_q;
        v0_d         = in_valid;
        x0_d         = in_valid ? x_c : x0_q;
        addr0_d      = in_valid ? phase_base_c[PHASE_W-1 -: LUT_ADDR_W] : addr0_q;

        // Stage 1: table lookup.
        v1_d   = v0_q & ~phase_reset;
        x1_d   = x0_q;
        cos1_d = cos_rom[addr0_q];
        sin1_d = sin_rom[addr0_q];

        // Stage 2: mix by e^(-j*theta).
        v2_d     = v1_q & ~phase_reset;
        prod_i_d = PROD_W'(x1_q) * PROD_W'(cos1_q);
        prod_q_d = -(PROD_W'(x1_q) * PROD_W'(sin1_q));

        // Stage 3: integrate-and-dump; the dump includes the current product.
        sum_i_c  = acc_i_q + ACC_W'(prod_i_q);
        sum_q_c  = acc_q_q + ACC_W'(prod_q_q);
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        cnt_d    = cnt_q;
        dump_i_d = dump_i_q;
        dump_q_d = dump_q_q;
        v3_d     = 1'b0;
        if (phase_reset) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (v2_q) begin
            if (cnt_q == CNT_LAST) begin
                dump_i_d = sum_i_c;
                dump_q_d = sum_q_c;
                acc_i_d  = '0;
                acc_q_d  = '0;
                cnt_d    = '0;
                v3_d     = 1'b1;
            end else begin
                acc_i_d = sum_i_c;
                acc_q_d = sum_q_c;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end

        // Stage 4: round/saturate; outputs hold while not valid.
        out_valid_d = v3_q & ~phase_reset;
        out_i_d     = out_valid_d ? round_sat(dump_i_q) : out_i_q;
        out_q_d     = out_valid_d ? round_sat(dump_q_q) : out_q_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= '0;
            tune_q      <= DEFAULT_TUNE;
            x0_q        <= '0;
            addr0_q     <= '0;
            v0_q        <= 1'b0;
            x1_q        <= '0;
            cos1_q      <= '0;
            sin1_q      <= '0;
            v1_q        <= 1'b0;
            prod_i_q    <= '0;
            prod_q_q    <= '0;
            v2_q        <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            dump_i_q    <= '0;
            dump_q_q    <= '0;
            v3_q        <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            tune_q      <= tune_d;
            x0_q        <= x0_d;
            addr0_q     <= addr0_d;
            v0_q        <= v0_d;
            x1_q        <= x1_d;
            cos1_q      <= cos1_d;
            sin1_q      <= sin1_d;
            v1_q        <= v1_d;
            prod_i_q    <= prod_i_d;
            prod_q_q    <= prod_q_d;
            v2_q        <= v2_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
            dump_i_q    <= dump_i_d;
            dump_q_q    <= dump_q_d;
            v3_q        <= v3_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ddc_core.sv
// tb_ddc_core: three ddc_core instances (DECIM 1, 2, 4) driven by shared stimulus,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_ddc_core;

    localparam logic [31:0] DEF_TUNE = 32'h3400_0000;
    localparam logic [31:0] QUARTER  = 32'h4000_0000;

    typedef struct {
        int i;
        int q;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [7:0]       in_data;
    logic             in_valid;
    logic [31:0]      tune_data;
    logic             tune_valid;
    logic             phase_reset;
    logic [2:0][7:0]  oi;
    logic [2:0][7:0]  oq;
    logic [2:0]       ov;

    int    checks = 0;
    int    errors = 0;
    exp_t  sb  [3][$];
    exp_t  got [3][$];

    // Reference model state
    int          cos_tab [1024];
    int          sin_tab [1024];
    bit [31:0]   m_phase;
    bit [31:0]   m_tune;
    longint      m_si [3];
    longint      m_sq [3];
    int          m_cnt [3];

    ddc_core #(.DECIM(1)) u_d1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .tune_data(tune_data), .tune_valid(tune_valid), .phase_reset(phase_reset),
        .out_i(oi[0]), .out_q(oq[0]), .out_valid(ov[0]));
    ddc_core #(.DECIM(2)) u_d2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .tune_data(tune_data), .tune_valid(tune_valid), .phase_reset(phase_reset),
        .out_i(oi[1]), .out_q(oq[1]), .out_valid(ov[1]));
    ddc_core #(.DECIM(4)) u_d4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .tune_data(tune_data), .tune_valid(tune_valid), .phase_reset(phase_reset),
        .out_i(oi[2]), .out_q(oq[2]), .out_valid(ov[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Divide by 2^sh with round-half-to-even, then clamp to 8-bit signed.
    function automatic int rnd_sat(input longint v, input int sh);
        longint div;
        longint rem;
        longint half;
        div  = v / (64'sd1 <<< sh);
        if (v < 0 && div * (64'sd1 <<< sh) != v) div = div - 1;
        rem  = v - div * (64'sd1 <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && (div % 2 != 0))) div = div + 1;
        if (div > 127) div = 127;
        if (div < -128) div = -128;
        return int'(div);
    endfunction

    task automatic flush_model();
        for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            m_si[k]  = 0;
            m_sq[k]  = 0;
            m_cnt[k] = 0;
        end
        m_phase = '0;
    endtask

    task automatic model_step(input bit iv, input logic [7:0] d, input bit tv,
                              input logic [31:0] td, input bit pr, input bit rst);
        int x;
        int a;
        exp_t e;
        if (rst) begin
            flush_model();
            m_tune = DEF_TUNE;
            return;
        end
        if (pr) flush_model();
        if (iv) begin
            x = int'(d) - 128;
            a = int'(m_phase / 32'd4194304);
            for (int k = 0; k < 3; k++) begin
                m_si[k] += longint'(x * cos_tab[a]);
                m_sq[k] -= longint'(x * sin_tab[a]);
                m_cnt[k]++;
                if (m_cnt[k] == (1 << k)) begin
                    e.i = rnd_sat(m_si[k], 13 + k);
                    e.q = rnd_sat(m_sq[k], 13 + k);
                    sb[k].push_back(e);
                    m_si[k]  = 0;
                    m_sq[k]  = 0;
                    m_cnt[k] = 0;
                end
            end
            m_phase = m_phase + m_tune;
        end
        if (tv) m_tune = td;
    endtask

    task automatic drive(input bit iv, input logic [7:0] d, input bit tv,
                         input logic [31:0] td, input bit pr, input bit rst);
        @(negedge clk);
        in_valid    = iv;
        in_data     = d;
        tune_valid  = tv;
        tune_data   = td;
        phase_reset = pr;
        reset       = rst;
        model_step(iv, d, tv, td, pr, rst);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 3; k++) got[k].delete();
    endtask

    task automatic restart_with_tune(input logic [31:0] tw);
        drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, tw, 1'b0, 1'b0);
        clear_logs();
    endtask

    // Expected quarter-rate results for +64 with phase starting at 0.
    task automatic check_quarter(input string tag);
        int ei;
        int eq;
        check({tag, "_n_d1"}, got[0].size(), 16);
        for (int n = 0; n < got[0].size() && n < 16; n++) begin
            ei = (n % 4 == 0) ? 64 : (n % 4 == 2) ? -64 : 0;
            eq = (n % 4 == 1) ? -64 : (n % 4 == 3) ? 64 : 0;
            check({tag, "_i_d1"}, got[0][n].i, ei);
            check({tag, "_q_d1"}, got[0][n].q, eq);
        end
        check({tag, "_n_d2"}, got[1].size(), 8);
        for (int n = 0; n < got[1].size() && n < 8; n++) begin
            check({tag, "_i_d2"}, got[1][n].i, (n % 2 == 0) ? 32 : -32);
            check({tag, "_q_d2"}, got[1][n].q, (n % 2 == 0) ? -32 : 32);
        end
        check({tag, "_n_d4"}, got[2].size(), 4);
        for (int n = 0; n < got[2].size() && n < 4; n++) begin
            check({tag, "_i_d4"}, got[2][n].i, 0);
            check({tag, "_q_d4"}, got[2][n].q, 0);
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid and logs what it saw.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    g.i = int'($signed(oi[k]));
                    g.q = int'($signed(oq[k]));
                    got[k].push_back(g);
                    if (sb[k].size() == 0) begin
                        check($sformatf("sb_unexpected_d%0d", 1 << k), 1, 0);
                    end else begin
                        e = sb[k].pop_front();
                        check($sformatf("sb_i_d%0d", 1 << k), g.i, e.i);
                        check($sformatf("sb_q_d%0d", 1 << k), g.q, e.q);
                    end
                end
            end
        end
    end

    initial begin
        int  lat;
        bit  seen;
        int  nv;
        bit  iv;
        bit  tv;
        bit  pr;
        bit  rst;

        for (int a = 0; a < 1024; a++) begin
            cos_tab[a] = $rtoi($floor(8191.0 * $cos(6.283185307179586 * a / 1024.0) + 0.5));
            sin_tab[a] = $rtoi($floor(8191.0 * $sin(6.283185307179586 * a / 1024.0) + 0.5));
        end
        m_tune = DEF_TUNE;
        flush_model();
        in_valid = 1'b0; in_data = 8'h00; tune_valid = 1'b0; tune_data = '0;
        phase_reset = 1'b0; reset = 1'b1;

        // Reset with a coincident sample, which must be dropped.
        drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            check("reset_out_i", int'(oi[k]), 0);
            check("reset_out_q", int'(oq[k]), 0);
            check("reset_out_valid", int'(ov[k]), 0);
        end

        // DC, tune = 0: latency then levels for +64, -128, +127.
        drive(1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0);
        clear_logs();
        drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        seen = 1'b0; lat = -1;
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            if (!seen && ov[0]) begin
                seen = 1'b1;
                lat = k - 1;
            end
        end
        check("latency_d1", lat, 4);
        for (int n = 0; n < 8; n++) drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int n = 0; n < 2; n++) drive(1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int n = 0; n < 2; n++) drive(1'b1, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(8);
        check("dc_count", got[0].size(), 13);
        for (int n = 0; n < got[0].size() && n < 13; n++) begin
            check("dc_i", got[0][n].i, (n < 9) ? 64 : (n < 11) ? -128 : 127);
            check("dc_q", got[0][n].q, 0);
        end

        // Quarter rate, continuous input.
        restart_with_tune(QUARTER);
        for (int n = 0; n < 16; n++) drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(8);
        check_quarter("quarter");

        // Quarter rate with in_valid toggling: identical sequence.
        restart_with_tune(QUARTER);
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
            idle(1);
        end
        idle(8);
        check_quarter("gapped");

        // Tune to 0 coincident with sample 5: phase freezes from sample 6.
        restart_with_tune(QUARTER);
        for (int n = 0; n < 12; n++) drive(1'b1, 8'hC0, n == 5, 32'h0, 1'b0, 1'b0);
        idle(8);
        check("tune_count", got[0].size(), 12);
        if (got[0].size() == 12) begin
            check("tune_s5_i", got[0][5].i, 0);
            check("tune_s5_q", got[0][5].q, -64);
            for (int n = 6; n < 12; n++) begin
                check("tune_const_i", got[0][n].i, -64);
                check("tune_const_q", got[0][n].q, 0);
            end
        end

        // phase_reset after 2 samples of a DECIM=4 block, 45-degree steps.
        restart_with_tune(32'h2000_0000);
        drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("prst_no_early_d4", got[2].size(), 0);
        seen = 1'b0; lat = -1;
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            if (!seen && ov[2]) begin
                seen = 1'b1;
                lat = k - 1;
            end
        end
        check("prst_latency_d4", lat, 4);
        check("prst_count_d4", got[2].size(), 1);
        if (got[2].size() == 1) begin
            check("prst_i_d4", got[2][0].i, 16);
            check("prst_q_d4", got[2][0].q, -39);
        end

        // Reset mid-operation: outputs clear, in-flight work vanishes.
        restart_with_tune(QUARTER);
        for (int n = 0; n < 6; n++) drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            check("midrst_out_i", int'(oi[k]), 0);
            check("midrst_out_q", int'(oq[k]), 0);
            check("midrst_out_valid", int'(ov[k]), 0);
        end
        clear_logs();
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            idle(1);
            nv += int'(ov[0]) + int'(ov[1]) + int'(ov[2]);
        end
        check("midrst_inflight_valids", nv, 0);
        // Default tuning word is back in force.
        for (int n = 0; n < 4; n++) drive(1'b1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(8);
        check("default_tune_count", got[0].size(), 4);
        if (got[0].size() == 4) begin
            check("default_tune_s0_i", got[0][0].i, 64);
            check("default_tune_s0_q", got[0][0].q, 0);
        end

        // Randomized traffic with tune loads, phase restarts and resets.
        for (int c = 0; c < 4000; c++) begin
            iv  = ($urandom % 4) != 0;
            tv  = ($urandom % 64) == 0;
            pr  = ($urandom % 97) == 0;
            rst = ($urandom % 701) == 0;
            if (rst) begin
                tv = 1'b0;
                pr = 1'b0;
            end
            drive(iv, 8'($urandom), tv, $urandom, pr, rst);
        end
        idle(10);
        for (int k = 0; k < 3; k++) check($sformatf("sb_drained_d%0d", 1 << k), sb[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
